// File: rtl/issue_scoreboard.sv
// Issue scoreboard: holds decoded instructions until their sources have no pending writes.
// Define SCOREBOARD_WB_BYPASS_EN to let a dependent instruction issue in its writeback cycle.
module issue_scoreboard #(
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  output logic        out_tvalid,
  input  logic        out_tready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        invalidate,
  output logic [31:0] busy,
  output logic [4:0]  inflight,
  output logic        wb_underflow
);

  localparam logic [CNT_W-1:0] CntMax      = {CNT_W{1'b1}};
  localparam logic [4:0]       InflightMax = 5'(MAX_INFLIGHT);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [4:0]       inflight_q, inflight_d;
  logic             underflow_q, underflow_d;

  logic             rs1_pend, rs2_pend, rs1_byp, rs2_byp;
  logic             rd_stall, hazard, issue, inc, dec, wb_hit;
  logic [CNT_W-1:0] wb_cnt;

  // Index 0 is never written, so cnt_q[0] reads as zero and x0 never creates a hazard.
  assign rs1_pend = (in_rs1 != 5'd0) && (cnt_q[in_rs1] != '0);
  assign rs2_pend = (in_rs2 != 5'd0) && (cnt_q[in_rs2] != '0);

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  // Last outstanding write to a source retiring now; the RF stage forwards its value.
  assign rs1_byp = wb_valid && (wb_rd == in_rs1) && (cnt_q[in_rs1] == CntOne);
  assign rs2_byp = wb_valid && (wb_rd == in_rs2) && (cnt_q[in_rs2] == CntOne);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign rd_stall = (in_rd != 5'd0) &&
                    ((cnt_q[in_rd] == CntMax) || (inflight_q == InflightMax));
  assign hazard   = (rs1_pend && !rs1_byp) || (rs2_pend && !rs2_byp) || rd_stall;

  // Both handshake outputs stay low while no instruction is presented.
  assign out_tvalid = in_tvalid && !hazard && !invalidate;
  assign in_tready  = in_tvalid && out_tready && !hazard && !invalidate;
  assign issue      = out_tvalid && out_tready;

  assign wb_hit = wb_valid && (wb_rd != 5'd0);
  assign wb_cnt = cnt_q[wb_rd];
  assign inc    = issue && (in_rd != 5'd0);
  assign dec    = wb_hit && (wb_cnt != '0);

  always_comb begin
    cnt_d       = cnt_q;
    inflight_d  = inflight_q;
    underflow_d = underflow_q;
    if (invalidate) begin
      for (int r = 0; r < 32; r++) begin
        cnt_d[r] = '0;
      end
      inflight_d = '0;
    end else begin
      if (!(inc && dec && (in_rd == wb_rd))) begin
        if (inc) cnt_d[in_rd] = cnt_q[in_rd] + CNT_W'(1);
        if (dec) cnt_d[wb_rd] = cnt_q[wb_rd] - CNT_W'(1);
      end
      if (inc && !dec) inflight_d = inflight_q + 5'd1;
      if (dec && !inc) inflight_d = inflight_q - 5'd1;
      if (wb_hit && (wb_cnt == '0)) underflow_d = 1'b1;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      inflight_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      inflight_q  <= inflight_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  assign inflight     = inflight_q;
  assign wb_underflow = underflow_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table, CNT_W=1 / async reset sequence,
// then random traffic against a counting reference model.
module tb_issue_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif
  localparam int MaxInfl = 4;
  localparam int MaxCnt  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_tvalid, out_tready, wb_valid, invalidate;
  logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd;
  logic        in_tready, out_tvalid, wb_underflow;
  logic [31:0] busy;
  logic [4:0]  inflight;
  logic        in_tready1, out_tvalid1, wb_underflow1;
  logic [31:0] busy1;
  logic [4:0]  inflight1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  issue_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(MaxInfl)) dut (
    .clk(clk), .rst(rst), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .wb_valid(wb_valid), .wb_rd(wb_rd), .invalidate(invalidate),
    .busy(busy), .inflight(inflight), .wb_underflow(wb_underflow)
  );

  issue_scoreboard #(.CNT_W(1), .MAX_INFLIGHT(MaxInfl)) dut1 (
    .clk(clk), .rst(rst), .in_tvalid(in_tvalid), .in_tready(in_tready1),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .out_tvalid(out_tvalid1),
    .out_tready(out_tready), .wb_valid(wb_valid), .wb_rd(wb_rd), .invalidate(invalidate),
    .busy(busy1), .inflight(inflight1), .wb_underflow(wb_underflow1)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic        rdy, wv;
    logic [4:0]  wrd;
    logic        inv;
    logic        e_ov, e_ir;
    logic [31:0] e_busy;
    logic [4:0]  e_infl;
    logic        e_uf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int v, int rs1, int rs2, int rd, int rdy, int wv, int wrd,
                              int inv, int ov, int ir, int eb, int ei, int uf);
    vec_t t;
    t.v = v[0]; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd);
    t.rdy = rdy[0]; t.wv = wv[0]; t.wrd = 5'(wrd); t.inv = inv[0];
    t.e_ov = ov[0]; t.e_ir = ir[0]; t.e_busy = 32'(eb); t.e_infl = 5'(ei); t.e_uf = uf[0];
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rdy, input logic wv,
                       input logic [4:0] wrd, input logic inv);
    in_tvalid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    out_tready = rdy; wb_valid = wv; wb_rd = wrd; invalidate = inv;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model state
  int  m_cnt [32];
  int  m_infl;
  bit  m_uf;

  initial begin
    rst = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    #12;
    chk("reset.busy", busy, 32'h0);
    chk("reset.inflight", 32'(inflight), 32'h0);
    chk("reset.underflow", 32'(wb_underflow), 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    rst = 1'b0;

    // ---------------- directed vector table ----------------
    vecs.push_back(mk(0,0,0,0,1, 0,0,0, 0,0,'h0,0,0));
    vecs.push_back(mk(1,1,2,3,1, 0,0,0, 1,1,'h8,1,0));
    vecs.push_back(mk(1,0,0,5,1, 0,0,0, 1,1,'h28,2,0));
    vecs.push_back(mk(1,5,0,0,1, 0,0,0, 0,0,'h28,2,0));
    vecs.push_back(mk(1,5,0,0,1, 1,5,0, Byp,Byp,'h8,1,0));
    vecs.push_back(mk(1,5,0,0,1, 0,0,0, 1,1,'h8,1,0));
    vecs.push_back(mk(1,0,0,1,1, 0,0,0, 1,1,'hA,2,0));
    vecs.push_back(mk(1,0,0,2,1, 0,0,0, 1,1,'hE,3,0));
    vecs.push_back(mk(1,0,0,4,1, 0,0,0, 1,1,'h1E,4,0));
    vecs.push_back(mk(1,0,0,6,1, 1,1,0, 0,0,'h1C,3,0));
    vecs.push_back(mk(1,0,0,6,1, 0,0,0, 1,1,'h5C,4,0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0, 1,0,'h5C,4,0));
    vecs.push_back(mk(0,0,0,0,1, 1,4,0, 0,0,'h4C,3,0));
    vecs.push_back(mk(0,0,0,0,1, 1,6,0, 0,0,'hC,2,0));
    vecs.push_back(mk(1,0,0,1,1, 0,0,0, 1,1,'hE,3,0));
    vecs.push_back(mk(1,0,0,5,1, 1,1,1, 0,0,'h0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,7,0, 0,0,'h0,0,1));
    vecs.push_back(mk(1,0,0,2,1, 0,0,0, 1,1,'h4,1,1));
    vecs.push_back(mk(1,0,0,2,1, 1,2,0, 1,1,'h4,1,1));
    vecs.push_back(mk(1,0,0,8,1, 1,2,0, 1,1,'h100,1,1));
    vecs.push_back(mk(1,0,0,8,1, 0,0,0, 1,1,'h100,2,1));
    vecs.push_back(mk(1,0,0,8,1, 0,0,0, 1,1,'h100,3,1));
    vecs.push_back(mk(1,0,0,8,1, 0,0,0, 0,0,'h100,3,1));
    vecs.push_back(mk(1,8,0,0,1, 1,8,0, 0,0,'h100,2,1));
    vecs.push_back(mk(0,0,0,0,1, 1,0,0, 0,0,'h100,2,1));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rdy,
            vecs[i].wv, vecs[i].wrd, vecs[i].inv);
      #1;
      chk($sformatf("vec%0d.out_tvalid", i), 32'(out_tvalid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d.in_tready", i), 32'(in_tready), 32'(vecs[i].e_ir));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d.inflight", i), 32'(inflight), 32'(vecs[i].e_infl));
      chk($sformatf("vec%0d.underflow", i), 32'(wb_underflow), 32'(vecs[i].e_uf));
    end

    // ---------------- CNT_W=1 saturation and async reset ----------------
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
    #1 chk("c1.first.out_tvalid", 32'(out_tvalid1), 32'h1);
    @(posedge clk); #1 chk("c1.first.busy", busy1, 32'h200);
    @(negedge clk);
    #1 chk("c1.sat.out_tvalid", 32'(out_tvalid1), 32'h0);
    @(posedge clk); #1 chk("c1.sat.inflight", 32'(inflight1), 32'h1);
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0);
    #1 chk("c1.wbcycle.out_tvalid", 32'(out_tvalid1), 32'h0);
    @(posedge clk); #1 chk("c1.wbcycle.busy", busy1, 32'h0);
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);
    #1 chk("c1.after.out_tvalid", 32'(out_tvalid1), 32'h1);
    @(posedge clk); #1 chk("c1.after.busy", busy1, 32'h200);
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async.busy1", busy1, 32'h0);
    chk("async.inflight1", 32'(inflight1), 32'h0);
    chk("async.busy", busy, 32'h0);
    chk("async.inflight", 32'(inflight), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- random traffic vs model ----------------
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_infl = 0;
    m_uf   = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int          pend[$];
      logic        v, rdy, wv, inv, e_ov, e_ir, haz;
      logic [4:0]  rs1, rs2, rd, wrd;
      logic [31:0] e_busy;
      @(negedge clk);
      pend = {};
      for (int r = 1; r < 8; r++) if (m_cnt[r] > 0) pend.push_back(r);
      v   = ($urandom_range(0, 3) != 0);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 3) != 0);
      inv = ($urandom_range(0, 31) == 0);
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        wv  = 1'b1;
        wrd = 5'(pend[$urandom_range(0, pend.size() - 1)]);
      end else begin
        wv  = ($urandom_range(0, 7) == 0);
        wrd = 5'd0;
      end
      drive(v, rs1, rs2, rd, rdy, wv, wrd, inv);

      haz = 1'b0;
      if (rs1 != 0 && m_cnt[rs1] > 0 && !(Byp && wv && wrd == rs1 && m_cnt[rs1] == 1))
        haz = 1'b1;
      if (rs2 != 0 && m_cnt[rs2] > 0 && !(Byp && wv && wrd == rs2 && m_cnt[rs2] == 1))
        haz = 1'b1;
      if (rd != 0 && (m_cnt[rd] == MaxCnt || m_infl == MaxInfl)) haz = 1'b1;
      e_ov = v && !haz && !inv;
      e_ir = e_ov && rdy;
      #1;
      chk($sformatf("rnd%0d.out_tvalid", c), 32'(out_tvalid), 32'(e_ov));
      chk($sformatf("rnd%0d.in_tready", c), 32'(in_tready), 32'(e_ir));

      @(posedge clk);
      #1;
      if (inv) begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_infl = 0;
      end else begin
        if (wv && wrd != 0) begin
          if (m_cnt[wrd] == 0) m_uf = 1'b1;
          else begin
            m_cnt[wrd]--;
            m_infl--;
          end
        end
        if (e_ir && rd != 0) begin
          m_cnt[rd]++;
          m_infl++;
        end
      end
      e_busy = '0;
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) e_busy[r] = 1'b1;
      chk($sformatf("rnd%0d.busy", c), busy, e_busy);
      chk($sformatf("rnd%0d.inflight", c), 32'(inflight), 32'(m_infl));
      chk($sformatf("rnd%0d.underflow", c), 32'(wb_underflow), 32'(m_uf));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
